// File: rtl/mxint8_seq_dot_engine.sv
// mxint8_seq_dot_engine
// Multi-cycle MXINT8 dot-product datapath. One A/B pair of MX blocks is accepted
// per valid/ready handshake: an E8M0 scale and BLOCK_SIZE int8 elements per operand.
// The element products are reduced LANES at a time into an exact fixed-point
// accumulator. The engine emits the raw integer sum, the combined unbiased exponent
// and the NaN/zero flags to the downstream float32 normaliser.
//
// Result interpretation: value = out_acc * 2^(out_exp - 12). Each element carries
// 6 fractional bits, so a product carries 12.
//
// Optional build macro MXINT8_NAN_SHORTCUT_EN: a block pair that carries a NaN scale
// skips accumulation. It goes straight from IDLE to DONE, and its result is presented
// one edge after acceptance with out_acc=0, out_zero=1 and out_nan=1. When the macro
// is undefined, NaN blocks take the full accumulate path. Their out_acc holds the
// true integer sum and out_nan is set.

`timescale 1ns/1ps

module mxint8_seq_dot_engine #(
    parameter int BLOCK_SIZE = 32,                          // elements per block, multiple of LANES
    parameter int LANES      = 4,                           // products summed per accumulate cycle
    parameter int ELEM_W     = 8,                           // int8 element, 6 fractional bits
    parameter int SCALE_W    = 8,                           // E8M0 scale, bias 127, all-ones = NaN
    parameter int ACC_W      = 2*ELEM_W + $clog2(BLOCK_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SCALE_W-1:0]           scale_a,
    input  logic [SCALE_W-1:0]           scale_b,
    input  logic [BLOCK_SIZE*ELEM_W-1:0] elements_a,
    input  logic [BLOCK_SIZE*ELEM_W-1:0] elements_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_W-1:0]      out_acc,
    output logic signed [9:0]            out_exp,
    output logic                         out_nan,
    output logic                         out_zero
);

    localparam int BEATS  = BLOCK_SIZE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int VEC_W  = BLOCK_SIZE * ELEM_W;
    localparam int LANE_W = LANES * ELEM_W;

    localparam logic [SCALE_W-1:0] NAN_SCALE = {SCALE_W{1'b1}};
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [9:0]         EXP_BIAS2 = 10'd254;    // two E8M0 biases of 127

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [BEAT_W-1:0]        beat;
    logic signed [ACC_W-1:0]  acc;
    logic [VEC_W-1:0]         a_q;
    logic [VEC_W-1:0]         b_q;

    logic                     nan_in;
    logic signed [9:0]        exp_in;
    logic signed [PROD_W-1:0] lane_prod [LANES];
    logic signed [ACC_W-1:0]  beat_sum;
    logic signed [ACC_W-1:0]  acc_next;

    // The engine only takes a new block pair while it sits in IDLE.
    assign in_ready = (state == IDLE);

    // The result flags are derived from the scales of the incoming block pair.
    // The exponent is computed in 10 bits, so 255+255-254 = 256 and 0+0-254 = -254
    // both fit without wrap.
    assign nan_in = (scale_a == NAN_SCALE) || (scale_b == NAN_SCALE);
    assign exp_in = $signed(10'(scale_a) + 10'(scale_b) - EXP_BIAS2);

    // The captured operands shift down by one beat's worth of elements every cycle.
    // As a result, the lanes always read the lowest LANES elements, and each lane
    // needs no variable index.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_prod[k] = $signed(a_q[k*ELEM_W +: ELEM_W]) * $signed(b_q[k*ELEM_W +: ELEM_W]);
    end

    // Sign-extend each 16-bit product and add it into the per-beat partial sum.
    always_comb begin
        // NOTE: assign a default before the loop so that every path writes beat_sum and no latch is inferred.
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + ACC_W'(lane_prod[k]);
        end
        acc_next = acc + beat_sum;
    end

    // Control FSM, operand shift registers, accumulator and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset as well. An aborted transaction then leaves no stale elements behind.
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_exp   <= '0;
            out_nan   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments only. Every register then samples the pre-edge value of every other register.
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q     <= elements_a;
                        b_q     <= elements_b;
                        acc     <= '0;
                        beat    <= '0;
                        out_nan <= nan_in;
                        out_exp <= exp_in;
                        state   <= ACCUM;
`ifdef MXINT8_NAN_SHORTCUT_EN
                        // NaN blocks skip accumulation. The later assignments override the ACCUM transition.
                        if (nan_in) begin
                            state    <= DONE;
                            out_acc  <= '0;
                            out_zero <= 1'b1;
                        end
`endif
                    end
                end

                ACCUM: begin
                    acc  <= acc_next;
                    beat <= beat + 1'b1;
                    a_q  <= a_q >> LANE_W;
                    b_q  <= b_q >> LANE_W;
                    if (beat == LAST_BEAT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_acc   <= acc_next;
                        out_zero  <= (acc_next == '0);
                    end
                end

                DONE: begin
`ifdef MXINT8_NAN_SHORTCUT_EN
                    // After a shortcut entry, the result becomes visible one edge after acceptance.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end
`endif
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxint8_seq_dot_engine.sv
// tb_mxint8_seq_dot_engine
// Self-checking bench for mxint8_seq_dot_engine at its default parameters. The
// expected results come from the dot-product definition, which is evaluated
// element by element with plain integer arithmetic. Outputs are sampled 1 ns after
// the rising edge. Inputs are driven on the falling edge.

`timescale 1ns/1ps

module tb_mxint8_seq_dot_engine;

    localparam int BS    = 32;
    localparam int LN    = 4;
    localparam int EW    = 8;
    localparam int SW    = 8;
    localparam int AW    = 2*EW + $clog2(BS);
    localparam int BEATS = BS / LN;
    localparam int VW    = BS * EW;

`ifdef MXINT8_NAN_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] scale_a;
    logic [SW-1:0] scale_b;
    logic [VW-1:0] elements_a;
    logic [VW-1:0] elements_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic [9:0]    out_exp;
    logic          out_nan;
    logic          out_zero;

    int checks = 0;
    int errors = 0;

    mxint8_seq_dot_engine #(
        .BLOCK_SIZE(BS),
        .LANES     (LN),
        .ELEM_W    (EW),
        .SCALE_W   (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scale_a   (scale_a),
        .scale_b   (scale_b),
        .elements_a(elements_a),
        .elements_b(elements_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_exp   (out_exp),
        .out_nan   (out_nan),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------

    function automatic int model_sum(input logic [VW-1:0] ea, input logic [VW-1:0] eb);
        int s = 0;
        for (int i = 0; i < BS; i++) begin
            s += int'($signed(ea[i*EW +: EW])) * int'($signed(eb[i*EW +: EW]));
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] splat(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < BS; i++) r[i*EW +: EW] = v[EW-1:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < BS; i++) begin
            r[i*EW +: EW] = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
        end
        return r;
    endfunction

    // ---------------- driver ----------------

    // This task drives one block pair, waits for acceptance, and then scrambles the
    // inputs. It returns the number of rising edges from acceptance to out_valid.
    // A value of -1 means out_valid never rose.
    task automatic send_block(input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                              input logic [VW-1:0] ea, input logic [VW-1:0] eb,
                              output int lat);
        lat = -1;
        @(negedge clk);
        scale_a    = sa;
        scale_b    = sb;
        elements_a = ea;
        elements_b = eb;
        in_valid   = 1'b1;
        for (int w = 0; w < 32 && in_ready !== 1'b1; w++) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        scale_a    = 8'($urandom);
        scale_b    = 8'($urandom);
        elements_a = rand_vec();
        elements_b = rand_vec();
        for (int k = 1; k <= 4*BEATS; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        scale_a    = '0;
        scale_b    = '0;
        elements_a = '0;
        elements_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        checks++; if (out_acc !== '0)     begin errors++; $display("FAIL reset_out_acc: got %0h, want 0", out_acc); end
        checks++; if (out_exp !== '0)     begin errors++; $display("FAIL reset_out_exp: got %0h, want 0", out_exp); end
        checks++; if (out_nan !== 1'b0)   begin errors++; $display("FAIL reset_out_nan: got %b, want 0", out_nan); end
        checks++; if (out_zero !== 1'b0)  begin errors++; $display("FAIL reset_out_zero: got %b, want 0", out_zero); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [SW-1:0] sa_t [4];
        logic [SW-1:0] sb_t [4];
        logic [VW-1:0] ea_t [4];
        logic [VW-1:0] eb_t [4];
        int            acc_t [4];
        int            exp_t [4];
        logic          nan_t [4];
        logic          zero_t [4];
        int            lat_t [4];
        logic [VW-1:0] alt;
        int            lat, wa, we;

        for (int i = 0; i < BS; i++) alt[i*EW +: EW] = (i % 2 == 0) ? 8'd10 : 8'hF6;

        sa_t   = '{8'd127, 8'd130, 8'd127, 8'hFF};
        sb_t   = '{8'd127, 8'd120, 8'd127, 8'd127};
        ea_t   = '{splat(64), splat(-128), alt, splat(2)};
        eb_t   = '{splat(64), splat(-128), splat(5), splat(1)};
        acc_t  = '{131072, 524288, 0, SHORTCUT ? 0 : 64};
        exp_t  = '{0, -4, 0, 128};
        nan_t  = '{1'b0, 1'b0, 1'b0, 1'b1};
        zero_t = '{1'b0, 1'b0, 1'b1, SHORTCUT};
        lat_t  = '{BEATS, BEATS, BEATS, SHORTCUT ? 1 : BEATS};

        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            send_block(sa_t[c], sb_t[c], ea_t[c], eb_t[c], lat);
            wa = acc_t[c];
            we = exp_t[c];
            checks++; if (lat !== lat_t[c])          begin errors++; $display("FAIL directed%0d_latency: got %0d edges, want %0d", c, lat, lat_t[c]); end
            checks++; if (out_acc !== wa[AW-1:0])   begin errors++; $display("FAIL directed%0d_acc: got %0d, want %0d", c, $signed(out_acc), wa); end
            checks++; if (out_exp !== we[9:0])      begin errors++; $display("FAIL directed%0d_exp: got %0d, want %0d", c, $signed(out_exp), we); end
            checks++; if (out_nan !== nan_t[c])     begin errors++; $display("FAIL directed%0d_nan: got %b, want %b", c, out_nan, nan_t[c]); end
            checks++; if (out_zero !== zero_t[c])   begin errors++; $display("FAIL directed%0d_zero: got %b, want %b", c, out_zero, zero_t[c]); end
        end
    endtask

    task automatic test_random();
        logic [SW-1:0] sa, sb;
        logic [VW-1:0] ea, eb;
        int            lat, s, e, wl;
        logic          nan, wz;

        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            sa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            sb = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            ea = rand_vec();
            eb = rand_vec();
            if (n == 5) eb = '0;
            nan = (sa == 8'hFF) || (sb == 8'hFF);
            s   = (SHORTCUT && nan) ? 0 : model_sum(ea, eb);
            e   = int'(sa) + int'(sb) - 254;
            wz  = (s == 0);
            wl  = (SHORTCUT && nan) ? 1 : BEATS;
            send_block(sa, sb, ea, eb, lat);
            checks++; if (lat !== wl)              begin errors++; $display("FAIL random%0d_latency: got %0d edges, want %0d", n, lat, wl); end
            checks++; if (out_acc !== s[AW-1:0])  begin errors++; $display("FAIL random%0d_acc: got %0d, want %0d", n, $signed(out_acc), s); end
            checks++; if (out_exp !== e[9:0])     begin errors++; $display("FAIL random%0d_exp: got %0d, want %0d", n, $signed(out_exp), e); end
            checks++; if (out_nan !== nan)        begin errors++; $display("FAIL random%0d_nan: got %b, want %b", n, out_nan, nan); end
            checks++; if (out_zero !== wz)        begin errors++; $display("FAIL random%0d_zero: got %b, want %b", n, out_zero, wz); end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] a1, b1, a2, b2;
        int            lat, s1, s2, e1, e2;

        a1 = rand_vec(); b1 = rand_vec();
        a2 = rand_vec(); b2 = rand_vec();
        s1 = model_sum(a1, b1);
        s2 = model_sum(a2, b2);
        e1 = 125 + 131 - 254;
        e2 = 100 + 140 - 254;

        out_ready = 1'b0;
        send_block(8'd125, 8'd131, a1, b1, lat);
        checks++; if (lat !== BEATS) begin errors++; $display("FAIL bp_first_latency: got %0d edges, want %0d", lat, BEATS); end

        // The second block is offered while the first result is stalled.
        @(negedge clk);
        scale_a = 8'd100; scale_b = 8'd140; elements_a = a2; elements_b = b2; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_hold%0d_valid: got %b, want 1", c, out_valid); end
            checks++; if (out_acc !== s1[AW-1:0]) begin errors++; $display("FAIL bp_hold%0d_acc: got %0d, want %0d", c, $signed(out_acc), s1); end
            checks++; if (out_exp !== e1[9:0])    begin errors++; $display("FAIL bp_hold%0d_exp: got %0d, want %0d", c, $signed(out_exp), e1); end
            checks++; if ({out_nan, out_zero} !== {1'b0, s1 == 0}) begin errors++; $display("FAIL bp_hold%0d_flags: got %b%b, want 0%b", c, out_nan, out_zero, s1 == 0); end
            checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL bp_hold%0d_in_ready: got %b, want 0", c, in_ready); end
            @(negedge clk);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b, want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready: got %b, want 1", in_ready); end

        send_block(8'd100, 8'd140, a2, b2, lat);
        checks++; if (lat !== BEATS)           begin errors++; $display("FAIL bp_second_latency: got %0d edges, want %0d", lat, BEATS); end
        checks++; if (out_acc !== s2[AW-1:0]) begin errors++; $display("FAIL bp_second_acc: got %0d, want %0d", $signed(out_acc), s2); end
        checks++; if (out_exp !== e2[9:0])    begin errors++; $display("FAIL bp_second_exp: got %0d, want %0d", $signed(out_exp), e2); end
    endtask

    task automatic test_mid_reset();
        logic [VW-1:0] a1, b1;
        int            lat, s1, e1, seen;

        a1 = rand_vec(); b1 = rand_vec();
        out_ready = 1'b1;

        @(negedge clk);
        scale_a = 8'd200; scale_b = 8'd90; elements_a = rand_vec(); elements_b = rand_vec(); in_valid = 1'b1;
        for (int w = 0; w < 32 && in_ready !== 1'b1; w++) @(negedge clk);
        @(posedge clk);                 // acceptance edge
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);      // the engine is now in its fourth beat
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, want 0", out_valid); end
        checks++; if (out_acc !== '0)     begin errors++; $display("FAIL midrst_acc: got %0h, want 0", out_acc); end
        checks++; if (out_exp !== '0)     begin errors++; $display("FAIL midrst_exp: got %0h, want 0", out_exp); end
        checks++; if ({out_nan, out_zero} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b%b, want 00", out_nan, out_zero); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %b, want 1", in_ready); end

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        seen = 0;
        for (int c = 0; c < 2*BEATS; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0)         begin errors++; $display("FAIL midrst_no_partial: out_valid high on %0d cycles, want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle_ready: got %b, want 1", in_ready); end

        s1 = model_sum(a1, b1);
        e1 = 140 + 115 - 254;
        send_block(8'd140, 8'd115, a1, b1, lat);
        checks++; if (lat !== BEATS)           begin errors++; $display("FAIL midrst_fresh_latency: got %0d edges, want %0d", lat, BEATS); end
        checks++; if (out_acc !== s1[AW-1:0]) begin errors++; $display("FAIL midrst_fresh_acc: got %0d, want %0d", $signed(out_acc), s1); end
        checks++; if (out_exp !== e1[9:0])    begin errors++; $display("FAIL midrst_fresh_exp: got %0d, want %0d", $signed(out_exp), e1); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mxint8_seq_dot_engine.md
Name: mxint8_seq_dot_engine

Overview:
Multi-cycle MXINT8 dot-product datapath. It consumes one pair of MX blocks (E8M0 scale plus BLOCK_SIZE int8 elements per operand) per valid/ready transaction. Elements are reduced LANES at a time into an exact fixed-point accumulator. It emits the raw integer sum, the combined unbiased exponent and flags to the downstream float32 normaliser. It sits directly behind the block-level stimulus/producer interface in the MXINT8 dot-product path.

Parameters:
BLOCK_SIZE, 32, elements per MX block; must be a multiple of LANES
LANES, 4, element products summed per accumulate cycle
ELEM_W, 8, MXINT8 element width (two's complement, 6 fractional bits)
SCALE_W, 8, E8M0 scale width (bias 127, 0xFF = NaN)
ACC_W, 2*ELEM_W+$clog2(BLOCK_SIZE), accumulator width (21 at defaults)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input block pair valid
in_ready  out  1  engine can accept a block pair
scale_a  in  SCALE_W  E8M0 scale of operand A
scale_b  in  SCALE_W  E8M0 scale of operand B
elements_a  in  BLOCK_SIZE*ELEM_W  packed A elements; element i at bits [i*ELEM_W +: ELEM_W]
elements_b  in  BLOCK_SIZE*ELEM_W  packed B elements, same packing
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_acc  out  ACC_W  signed sum of a[i]*b[i]; value = out_acc * 2^(out_exp-12)
out_exp  out  10  signed: scale_a + scale_b - 254
out_nan  out  1  either scale == 0xFF
out_zero  out  1  out_acc == 0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; beat counter, accumulator and captured operands cleared.
  - out_valid=0, out_acc=0, out_exp=0, out_nan=0, out_zero=0.
  - in_ready=1 (it is a decode of IDLE).
- Reset mid-operation aborts the transaction; no partial result is ever emitted.
- FSM IDLE -> ACCUM -> DONE -> IDLE. BEATS = BLOCK_SIZE/LANES.
- IDLE:
  - in_ready=1.
  - Handshake on in_valid && in_ready at a rising edge:
    - register both scales and both element vectors;
    - clear acc and beat=0;
    - register out_nan = (scale_a==0xFF)|(scale_b==0xFF);
    - register out_exp = sign-extended scale_a + scale_b - 254 (computed in 10 bits);
    - go to ACCUM.
  - Inputs are ignored when there is no handshake.
- ACCUM:
  - in_ready=0.
  - Each edge: acc += sum over lanes of signed(a[beat*LANES+k]) * signed(b[beat*LANES+k]), using 16-bit signed products and ACC_W-bit signed addition.
  - beat increments each edge.
  - At the edge where beat==BEATS-1: go to DONE, out_valid=1, out_acc=final sum.
- Latency: out_valid rises exactly BEATS edges after the acceptance edge (8 at defaults).
- Overflow: none is possible. Worst case is BLOCK_SIZE*(-128*-128) = 524288, which fits in 21-bit signed.
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0, return to IDLE. in_ready is 1 in the following cycle.
  - There is no same-cycle input acceptance in DONE.
- out_zero is registered together with out_acc. It is valid whenever out_valid=1.
- out_nan does not gate arithmetic unless the optional feature is enabled.
- Elements of -128 are legal and processed exactly.

Optional Feature:
Macro MXINT8_NAN_SHORTCUT_EN.
- Defined: a handshake where either scale is 0xFF goes directly IDLE -> DONE.
  - out_valid rises 1 edge after acceptance.
  - out_acc=0, out_zero=1, out_nan=1, out_exp as computed.
- Undefined: NaN blocks take the full BEATS-cycle ACCUM path; out_acc holds the true integer sum; out_nan=1.

Test Plan:
- All a=64, all b=64, scale_a=scale_b=127, out_ready=1 -> out_valid 8 edges after accept; out_acc=131072, out_exp=0, out_nan=0, out_zero=0.
- All a=b=-128 (0x80), scale_a=130, scale_b=120 -> out_acc=524288, out_exp=-4, no wrap.
- a[i]=+10 for even i and -10 for odd i, all b=5, scales 127/127 -> out_acc=0, out_zero=1.
- scale_a=0xFF, b all 1, a all 2 -> out_nan=1.
  - Without the macro: out_acc=64 after 8 edges.
  - With MXINT8_NAN_SHORTCUT_EN: out_valid 1 edge after accept, out_acc=0, out_zero=1.
- out_ready held 0 for 5 cycles after out_valid -> out_acc/out_exp/flags stable, in_ready=0, a second in_valid is not accepted. out_ready=1 -> in_ready=1 the next cycle and the second block is accepted.
- rst_n pulsed low during ACCUM beat 3 -> out_valid=0 and all outputs 0 immediately (asynchronous). After release in_ready=1 and a fresh block completes with the correct result.
